// File: rtl/ff_conv_arbiter.sv
// ff_conv_arbiter
//   Round-robin arbiter/sequencer that shares one float-to-fixed converter
//   (FSM_FF controller) among N_REQ requesters. It grants one requester,
//   registers that requester's operand toward the converter, and runs the
//   Begin/ACK/release handshake. It then returns the fixed-point result with a
//   DONE pulse for the granted requester. A watchdog aborts with ERR when ACK
//   does not arrive within TIMEOUT cycles of entering WAIT.
//
// Ports
//   CLK, RST        clock, asynchronous active-high reset
//   REQ[N_REQ]      level requests, sampled only while idle
//   DATA_IN         packed operands, requester i at [i*W_FLT +: W_FLT]
//   GNT             one-hot grant, held from operand latch to return to idle
//   DONE            one-cycle pulse to the granted requester, RESULT valid
//   ERR             one-cycle pulse on timeout abort (GNT names the victim)
//   BUSY            high in every state except idle
//   RESULT          last captured converter result
//   FLT_OUT         registered operand to the converter
//   BEGIN_FF        start strobe to the converter
//   RST_FSM_FF      release strobe to the converter FSM
//   ACK_FF, FIX_IN  converter done level and its result
module ff_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W_FLT   = 32,
  parameter int W_FIX   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*W_FLT-1:0] DATA_IN,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       DONE,
  output logic                   ERR,
  output logic                   BUSY,
  output logic [W_FIX-1:0]       RESULT,
  output logic [W_FLT-1:0]       FLT_OUT,
  output logic                   BEGIN_FF,
  output logic                   RST_FSM_FF,
  input  logic                   ACK_FF,
  input  logic [W_FIX-1:0]       FIX_IN
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [TW-1:0]   timer, timer_n;

  logic [N_REQ-1:0] gnt_n, done_n;
  logic             err_n, busy_n, begin_n, rstff_n;
  logic [W_FIX-1:0] result_n;
  logic [W_FLT-1:0] flt_n;

  logic [IW-1:0]    pick_idx;
  logic             pick_ok;
  int unsigned      cand;

  // First requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    pick_idx = '0;
    pick_ok  = 1'b0;
    cand     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = k + 32'(ptr);
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_ok && REQ[IW'(cand)]) begin
        pick_idx = IW'(cand);
        pick_ok  = 1'b1;
      end
    end
  end

  // Next-state and next-output values; every output is then registered so
  // each strobe lines up with the state it belongs to.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    ptr_n    = ptr;
    timer_n  = timer;
    gnt_n    = GNT;
    done_n   = '0;
    err_n    = 1'b0;
    busy_n   = BUSY;
    result_n = RESULT;
    flt_n    = FLT_OUT;
    begin_n  = 1'b0;
    rstff_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_ok) begin
          idx_n           = pick_idx;
          gnt_n           = '0;
          gnt_n[pick_idx] = 1'b1;
          flt_n           = DATA_IN[pick_idx*W_FLT +: W_FLT];
          busy_n          = 1'b1;
          begin_n         = 1'b1;
          state_n         = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        timer_n = timer + 1'b1;
        if (ACK_FF) begin
          result_n    = FIX_IN;
          done_n[idx] = 1'b1;
          rstff_n     = 1'b1;
          state_n     = S_RELEASE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          rstff_n = 1'b1;
          state_n = S_RELEASE;
        end
      end
      S_RELEASE: begin
        rstff_n = 1'b1;
        if (!ACK_FF) begin
          gnt_n   = '0;
          ptr_n   = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
          busy_n  = 1'b0;
          rstff_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      idx        <= '0;
      ptr        <= '0;
      timer      <= '0;
      GNT        <= '0;
      DONE       <= '0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
      RESULT     <= '0;
      FLT_OUT    <= '0;
      BEGIN_FF   <= 1'b0;
      RST_FSM_FF <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      ptr        <= ptr_n;
      timer      <= timer_n;
      GNT        <= gnt_n;
      DONE       <= done_n;
      ERR        <= err_n;
      BUSY       <= busy_n;
      RESULT     <= result_n;
      FLT_OUT    <= flt_n;
      BEGIN_FF   <= begin_n;
      RST_FSM_FF <= rstff_n;
    end
  end

endmodule

// File: doc/ff_conv_arbiter.md
# ff_conv_arbiter

Round-robin arbiter and sequencer that shares one float-to-fixed conversion unit among N requesters. It sits between requester blocks (CORDIC stages, accumulators) and the converter datapath with its FSM_FF controller. It drives that controller's Begin/ACK/reset handshake, steers the selected requester's operand in, and returns the fixed-point result with a per-requester done pulse. A watchdog recovers the unit if ACK never arrives.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W_FLT, 32, floating-point operand width
- W_FIX, 32, fixed-point result width
- TIMEOUT, 64, max cycles in WAIT before abort (≥4)
- CLK  in  1  system clock
- RST  in  1  system reset; one clock, reset is asynchronous and active-high
- REQ  in  N_REQ  level request per requester; held until its DONE or ERR
- DATA_IN  in  N_REQ*W_FLT  operand of requester i at bits [i*W_FLT +: W_FLT]
- GNT  out  N_REQ  one-hot grant; held from operand latch until return to IDLE
- DONE  out  N_REQ  one-cycle pulse to the granted requester when RESULT is valid
- ERR  out  1  one-cycle pulse on timeout abort; GNT identifies the victim
- BUSY  out  1  high in every state except IDLE
- RESULT  out  W_FIX  last captured result; holds between conversions
- FLT_OUT  out  W_FLT  registered operand to converter
- BEGIN_FF  out  1  start strobe to converter (FSM_FF Begin_FSM_FF)
- RST_FSM_FF  out  1  release strobe to converter FSM
- ACK_FF  in  1  converter done, level; held until RST_FSM_FF is seen
- FIX_IN  in  W_FIX  converter result; valid while ACK_FF=1

## Operation
- All outputs are registered. Reset value is 0 for GNT, DONE, ERR, BUSY, RESULT, FLT_OUT, BEGIN_FF, and RST_FSM_FF. Reset also sets state=IDLE, pointer=0, and timer=0.
- IDLE: REQ is sampled here only. If REQ≠0, pick the first set bit scanning from pointer upward, modulo N_REQ. Latch that index, set GNT, and load FLT_OUT from DATA_IN[idx]. Go to LAUNCH.
- LAUNCH: BEGIN_FF=1 for exactly this one cycle. Clear timer. Go to WAIT.
- WAIT: increment timer each cycle.
  - ACK_FF=1: RESULT←FIX_IN, DONE[idx]=1 (one cycle), go to RELEASE.
  - Otherwise, if timer reaches TIMEOUT-1: ERR=1 (one cycle), RESULT unchanged, no DONE, go to RELEASE.
  - ACK has priority over timeout in the same cycle.
- RELEASE: RST_FSM_FF=1 while in this state. When ACK_FF=0 is sampled: GNT←0, pointer←(idx+1) mod N_REQ, go to IDLE.
- Pointer advances after both success and abort, so a faulty requester cannot starve others.
- REQ dropped mid-operation: the conversion still completes and DONE/ERR still pulses. Changes to DATA_IN after the latch have no effect.
- A requester that keeps REQ high after DONE is treated as a new request and is rescheduled per round-robin.
- Assertion of RST in any state forces reset values immediately. An outstanding conversion is abandoned. The converter is reset by its own RST_FF, which is tied to the same RST.

## Timing
- Grant latency: REQ sampled at edge t gives GNT/FLT_OUT/BUSY at t+1, with BEGIN_FF high during cycle t+1..t+2.
- Result latency: ACK_FF sampled high at edge u gives RESULT and DONE at u+1, with RST_FSM_FF high from u+1.
- Release: ACK_FF low sampled at edge v gives IDLE at v+1 with GNT=0 and BUSY=0. The earliest next GNT is v+2.
- Minimum turnaround per conversion is converter latency + 4 cycles.
- Timeout: ERR asserts TIMEOUT cycles after entering WAIT.
- Only one BEGIN_FF is issued per grant. BEGIN_FF and RST_FSM_FF are never high together.

## Test plan
- Single request: REQ=4'b0100 with DATA_IN[2]=0x3F800000 (1.0), converter model ACKs after 12 cycles with FIX_IN=0x00010000. Expect GNT=4'b0100, one BEGIN_FF pulse, DONE[2] pulse, RESULT=0x00010000, then return to IDLE.
- Contention: REQ=4'b1111 held continuously from reset. Expect grant order 0,1,2,3,0, exactly one DONE per grant, and one-hot GNT throughout.
- Fairness after service: pointer=2 with REQ=4'b0011. Expect grant to 0 then 1, never 1 first.
- Timeout: model never ACKs, TIMEOUT=64. Expect ERR exactly 64 cycles after WAIT entry, no DONE, RESULT unchanged, pointer advanced, and the next request served normally.
- Reset mid-operation: assert RST in WAIT. Expect all outputs 0 asynchronously, pointer=0, and normal service after release.
- Request withdrawn: drop REQ[1] two cycles after GNT. Expect the conversion to complete, DONE[1] to pulse, and no re-grant to requester 1 while its REQ is low.
